// File: rtl/pipe_adder_res_fifo_if.sv
// Adder-result stream: the upstream half carries results in and stall back out,
// and the downstream half is an FWFT valid/ready port toward the consumer.
interface pipe_adder_res_fifo_if #(
  parameter int W = 32
);
  logic         in_vld;
  logic [W-1:0] in_result;
  logic         stall;
  logic         out_vld;
  logic [W-1:0] out_data;
  logic         out_rdy;

  // FIFO side
  modport master (
    input  in_vld, in_result, out_rdy,
    output stall, out_vld, out_data
  );

  // Adder and consumer side
  modport slave (
    output in_vld, in_result, out_rdy,
    input  stall, out_vld, out_data
  );
endinterface

// File: rtl/pipe_adder_res_fifo.sv
// FWFT result FIFO behind the pipelined adder. in_vld -> out_vld takes 1 cycle.
// Stall is raised when full or on ext_stall, and it never depends on out_rdy, so the held adder result is written once.
module pipe_adder_res_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     ext_stall,
  pipe_adder_res_fifo_if.master    bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign full         = (count == CW'(DEPTH));
  assign bus.stall    = full | ext_stall;
  assign bus.out_vld  = (count != '0);
  assign bus.out_data = mem[rd_ptr];

  assign push = bus.in_vld & ~bus.stall;
  assign pop  = bus.out_vld & bus.out_rdy;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      // flush wins over a same-cycle push or pop; the in-flight result is dropped
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= bus.in_result;
  end
endmodule

// File: tb/tb_pipe_adder_res_fifo.sv
// Directed bench for pipe_adder_res_fifo with a queue scoreboard and a negedge monitor.
module tb_pipe_adder_res_fifo;
  localparam int W     = 32;
  localparam int DEPTH = 4;

  logic       clk;
  logic       resetn;
  logic       flush;
  logic       ext_stall;
  logic [2:0] count;
  logic       full;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q [$];

  pipe_adder_res_fifo_if #(.W(W)) bus ();

  pipe_adder_res_fifo #(.W(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .ext_stall (ext_stall),
    .bus       (bus),
    .count     (count),
    .full      (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [W-1:0] d, input logic rdy);
    bus.in_vld    = vld;
    bus.in_result = d;
    bus.out_rdy   = rdy;
  endtask

  // Monitor: every accepted head entry must match the oldest expected result.
  always @(negedge clk) begin
    if (resetn) begin
      checks++;
      if (count > 3'(DEPTH)) begin
        errors++;
        $display("FAIL occupancy_bound: count %0d exceeds %0d", count, DEPTH);
      end
      if (bus.out_vld && bus.out_rdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got 0x%08h with nothing expected at %0t", bus.out_data, $time);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          if (bus.out_data !== e) begin
            errors++;
            $display("FAIL out_data: got 0x%08h expected 0x%08h at %0t", bus.out_data, e, $time);
          end
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    resetn    = 1'b0;
    flush     = 1'b0;
    ext_stall = 1'b1;
    drive(1'b0, '0, 1'b0);
    #12;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_vld", 32'(bus.out_vld), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_stall_ext1", 32'(bus.stall), 32'd1);
    ext_stall = 1'b0;
    #1;
    chk("rst_stall_ext0", 32'(bus.stall), 32'd0);
    #3 resetn = 1'b1;
    step();

    // Single transaction
    drive(1'b1, 32'h0000_00FF, 1'b1);
    exp_q.push_back(32'h0000_00FF);
    step();
    drive(1'b0, '0, 1'b1);
    chk("single_count1", 32'(count), 32'd1);
    chk("single_vld1", 32'(bus.out_vld), 32'd1);
    chk("single_data", bus.out_data, 32'h0000_00FF);
    step();
    chk("single_count0", 32'(count), 32'd0);
    chk("single_vld0", 32'(bus.out_vld), 32'd0);

    // Fill to full, then pop once and let the held 0x55 in
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'(i * 'h11), 1'b0);
      exp_q.push_back(32'(i * 'h11));
      step();
    end
    drive(1'b1, 32'h55, 1'b0);
    chk("fill_count4", 32'(count), 32'd4);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_stall", 32'(bus.stall), 32'd1);
    step();
    chk("fill_hold_count", 32'(count), 32'd4);
    drive(1'b1, 32'h55, 1'b1);
    exp_q.push_back(32'h55);
    step();
    drive(1'b1, 32'h55, 1'b0);
    chk("fill_pop_count", 32'(count), 32'd3);
    chk("fill_stall_drop", 32'(bus.stall), 32'd0);
    step();
    drive(1'b0, '0, 1'b0);
    chk("fill_refill_count", 32'(count), 32'd4);
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) step();
    chk("fill_drained", 32'(count), 32'd0);

    // Simultaneous push/pop at count 2, including pointer wrap
    drive(1'b1, 32'hA, 1'b0); exp_q.push_back(32'hA); step();
    drive(1'b1, 32'hB, 1'b0); exp_q.push_back(32'hB); step();
    drive(1'b1, 32'hC, 1'b1); exp_q.push_back(32'hC); step();
    chk("pp_count", 32'(count), 32'd2);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'(32'h100 + i), 1'b1);
      exp_q.push_back(32'(32'h100 + i));
      step();
      chk("pp_wrap_count", 32'(count), 32'd2);
    end
    drive(1'b0, '0, 1'b1);
    step(); step();
    chk("pp_drained", 32'(count), 32'd0);

    // Flush with simultaneous push and pop
    drive(1'b0, '0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 32'(i), 1'b0);
      exp_q.push_back(32'(i));
      step();
    end
    chk("flush_pre_count", 32'(count), 32'd3);
    drive(1'b1, 32'h99, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    exp_q.delete();
    drive(1'b0, '0, 1'b1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_out_vld", 32'(bus.out_vld), 32'd0);
    step();
    drive(1'b1, 32'h77, 1'b0); exp_q.push_back(32'h77); step();
    drive(1'b0, '0, 1'b1);
    chk("flush_next_data", bus.out_data, 32'h77);
    step();

    // ext_stall blocks pushes, not pops
    drive(1'b1, 32'hD1, 1'b0); exp_q.push_back(32'hD1); step();
    drive(1'b1, 32'hD2, 1'b0); exp_q.push_back(32'hD2); step();
    ext_stall = 1'b1;
    drive(1'b1, 32'hEE, 1'b1);
    #1;
    chk("xs_stall", 32'(bus.stall), 32'd1);
    step();
    chk("xs_count1", 32'(count), 32'd1);
    step();
    chk("xs_count0", 32'(count), 32'd0);
    chk("xs_out_vld0", 32'(bus.out_vld), 32'd0);
    ext_stall = 1'b0;
    drive(1'b1, 32'hEE, 1'b0);
    exp_q.push_back(32'hEE);
    #1;
    chk("xs_release_stall", 32'(bus.stall), 32'd0);
    step();
    drive(1'b0, '0, 1'b1);
    chk("xs_release_count", 32'(count), 32'd1);
    step();
    chk("xs_release_drain", 32'(count), 32'd0);

    // Asynchronous reset mid-stream
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 32'(32'hF0 + i), 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b0);
    chk("arst_pre_count", 32'(count), 32'd3);
    #2 resetn = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_out_vld", 32'(bus.out_vld), 32'd0);
    #1 resetn = 1'b1;
    step();
    drive(1'b1, 32'h1234_5678, 1'b1);
    exp_q.push_back(32'h1234_5678);
    step();
    drive(1'b0, '0, 1'b1);
    chk("arst_first_data", bus.out_data, 32'h1234_5678);
    step();
    chk("arst_final_count", 32'(count), 32'd0);

    step();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
